// File: rtl/sdm_ctrl_pkg.sv
// Shared types, widths and gain helpers for the sigma-delta stream sequencer.
package sdm_ctrl_pkg;

  localparam int unsigned GAIN_W   = 9;
  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned PROD_W   = 25;

  localparam logic [GAIN_W-1:0] GAIN_ONE = 9'd256;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StRampUp   = 3'd1,
    StRun      = 3'd2,
    StRampDown = 3'd3,
    StMuted    = 3'd4
  } sdm_state_e;

  function automatic logic [GAIN_W-1:0] gain_up(input logic [GAIN_W-1:0] g,
                                                input logic [GAIN_W-1:0] step);
    logic [GAIN_W:0] sum;
    sum = {1'b0, g} + {1'b0, step};
    return (sum > {1'b0, GAIN_ONE}) ? GAIN_ONE : sum[GAIN_W-1:0];
  endfunction

  function automatic logic [GAIN_W-1:0] gain_down(input logic [GAIN_W-1:0] g,
                                                  input logic [GAIN_W-1:0] step);
    return (g > step) ? g - step : '0;
  endfunction

endpackage

// File: rtl/sdm_gain_scaler.sv
// Signed sample times unsigned gain, floor-shifted by 8, held in an output register.
module sdm_gain_scaler
  import sdm_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [GAIN_W-1:0]   gain,
  output logic [SAMPLE_W-1:0] result
);

  logic signed [PROD_W-1:0] prod;

  // Gain is unsigned; the zero MSB keeps it positive in the signed multiply.
  always_comb begin
    prod = PROD_W'($signed(sample)) * PROD_W'($signed({1'b0, gain}));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
    end else if (load) begin
      result <= SAMPLE_W'(prod >>> 8);
    end
  end

endmodule

// File: rtl/sdm_stream_sequencer.sv
// Sample-rate sequencer and soft-mute ramp controller feeding the sigma-delta modulator.
module sdm_stream_sequencer
  import sdm_ctrl_pkg::*;
#(
  parameter int unsigned GAIN_STEP = 8,
  parameter int unsigned DIV_W     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                mute,
  input  logic [DIV_W-1:0]    osr_div,
  input  logic                s_valid,
  input  logic [SAMPLE_W-1:0] s_data,
  output logic                s_ready,
  output logic [SAMPLE_W-1:0] sd_in,
  output logic                sd_rst_n,
  output logic [15:0]         underrun_cnt,
  output logic [2:0]          state
);

  localparam logic [GAIN_W-1:0] Step = GAIN_W'(GAIN_STEP);

  sdm_state_e          state_q, state_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [GAIN_W-1:0]   g_q, g_d;
  logic [SAMPLE_W-1:0] held_q, held_d;
  logic [SAMPLE_W-1:0] sample_sel;
  logic [15:0]         under_q, under_d;
  logic                sd_rst_n_q;
  logic                strobe;

  assign strobe     = (cnt_q == '0) && (state_q != StIdle);
  assign sample_sel = s_valid ? s_data : held_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Gain moves only on strobes; a turnaround strobe keeps the current gain.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    unique case (state_q)
      StIdle: begin
        g_d = '0;
        if (en) state_d = StRampUp;
      end
      StRampUp: begin
        if (strobe) begin
          if (!en || mute) begin
            state_d = StRampDown;
          end else begin
            g_d = gain_up(g_q, Step);
            if (g_d == GAIN_ONE) state_d = StRun;
          end
        end
      end
      StRun: begin
        if (strobe && (!en || mute)) state_d = StRampDown;
      end
      StRampDown: begin
        if (strobe) begin
          g_d = gain_down(g_q, Step);
          if (g_d == '0) begin
            if (!en)       state_d = StIdle;
            else if (mute) state_d = StMuted;
            else           state_d = StRampUp;
          end
        end
      end
      StMuted: begin
        if (strobe) begin
          g_d = '0;
          if (!en)       state_d = StIdle;
          else if (!mute) state_d = StRampUp;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    s_ready      = strobe;
    state        = state_q;
    sd_rst_n     = sd_rst_n_q;
    underrun_cnt = under_q;
  end

  always_comb begin
    cnt_d   = cnt_q;
    held_d  = held_q;
    under_d = under_q;
    if (state_q == StIdle || state_d == StIdle) begin
      cnt_d = '0;
    end else if (strobe) begin
      cnt_d = osr_div;
    end else begin
      cnt_d = cnt_q - DIV_W'(1);
    end
    if (state_d == StIdle) begin
      held_d = '0;
    end else if (strobe && s_valid) begin
      held_d = s_data;
    end
    if (state_q == StIdle && state_d == StRampUp) begin
      under_d = '0;
    end else if (strobe && !s_valid && under_q != 16'hFFFF) begin
      under_d = under_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      g_q        <= '0;
      held_q     <= '0;
      under_q    <= '0;
      sd_rst_n_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      g_q        <= g_d;
      held_q     <= held_d;
      under_q    <= under_d;
      sd_rst_n_q <= (state_d != StIdle);
    end
  end

  sdm_gain_scaler u_scaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (strobe || (state_q == StIdle)),
    .sample (sample_sel),
    .gain   (g_d),
    .result (sd_in)
  );

endmodule

// File: tb/tb_sdm_stream_sequencer.sv
// Directed and randomized checks of sdm_stream_sequencer against a strobe-level model.
module tb_sdm_stream_sequencer;

  localparam int GS = 64;

  logic        clk = 1'b0;
  logic        rst_n, en, mute, s_valid;
  logic [7:0]  osr_div;
  logic [15:0] s_data;
  logic        s_ready, sd_rst_n;
  logic [15:0] sd_in, underrun_cnt;
  logic [2:0]  state;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: mode 0..4, gain 0..256, clocks left until next strobe, held sample, output.
  int m_state, m_g, m_wait, m_hold, m_sd, m_under;
  bit m_rstn_out, last_strobe;

  sdm_stream_sequencer #(.GAIN_STEP(GS), .DIV_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .mute         (mute),
    .osr_div      (osr_div),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .sd_in        (sd_in),
    .sd_rst_n     (sd_rst_n),
    .underrun_cnt (underrun_cnt),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int floor_scale(input int s, input int g);
    int p;
    p = s * g;
    if (p >= 0) return p / 256;
    return -((-p + 255) / 256);
  endfunction

  task automatic model_reset();
    m_state = 0; m_g = 0; m_wait = 0; m_hold = 0; m_sd = 0; m_under = 0;
    m_rstn_out = 1'b0;
  endtask

  task automatic model_edge();
    int smp;
    last_strobe = (m_state != 0) && (m_wait == 0);
    if (!rst_n) begin
      model_reset();
      last_strobe = 1'b0;
      return;
    end
    if (m_state == 0) begin
      if (en) begin
        m_state = 1;
        m_under = 0;
      end
    end else if (last_strobe) begin
      if (s_valid) smp = int'($signed(s_data));
      else begin
        smp = m_hold;
        if (m_under < 65535) m_under++;
      end
      case (m_state)
        1: if (!en || mute) m_state = 3;
           else begin
             m_g = (m_g + GS > 256) ? 256 : m_g + GS;
             if (m_g == 256) m_state = 2;
           end
        2: if (!en || mute) m_state = 3;
        3: begin
             m_g = (m_g > GS) ? m_g - GS : 0;
             if (m_g == 0) m_state = !en ? 0 : (mute ? 4 : 1);
           end
        default: begin
             m_g = 0;
             if (!en) m_state = 0;
             else if (!mute) m_state = 1;
           end
      endcase
      m_sd   = floor_scale(smp, m_g);
      m_hold = (m_state == 0) ? 0 : smp;
      m_wait = (m_state == 0) ? 0 : int'(osr_div);
    end else begin
      m_wait--;
    end
    m_rstn_out = (m_state != 0);
  endtask

  // One clock: called just after a falling edge with inputs already driven.
  task automatic cyc();
    #1;
    chk("s_ready", s_ready, (m_state != 0 && m_wait == 0) ? 1 : 0);
    @(posedge clk);
    model_edge();
    #1;
    chk("sd_in", sd_in, m_sd & 32'hFFFF);
    chk("sd_rst_n", sd_rst_n, m_rstn_out);
    chk("state", state, m_state);
    chk("underrun_cnt", underrun_cnt, m_under);
    @(negedge clk);
  endtask

  task automatic next_strobe();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      cyc();
      got = last_strobe;
    end
    chk("strobe_wait", got, 1);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mute = 1'b0; s_valid = 1'b0;
    osr_div = 8'd3; s_data = 16'h0000;
    model_reset();
    @(negedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_sd_in", sd_in, 16'h0000);
    chk("rst_sd_rst_n", sd_rst_n, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_underrun", underrun_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ramp up to unity with a constant full-valid stream.
    en = 1'b1; s_valid = 1'b1; s_data = 16'h4000;
    cyc();
    next_strobe();
    chk("up1_sd_in", sd_in, 16'h1000);
    chk("up1_sd_rst_n", sd_rst_n, 1);
    next_strobe(); chk("up2_sd_in", sd_in, 16'h2000);
    next_strobe(); chk("up3_sd_in", sd_in, 16'h3000);
    next_strobe(); chk("up4_sd_in", sd_in, 16'h4000);
    chk("up4_state", state, 2);

    // Underruns in RUN reuse the held sample.
    s_valid = 1'b0; s_data = 16'h1234;
    repeat (3) next_strobe();
    chk("ur_count", underrun_cnt, 3);
    chk("ur_sd_in", sd_in, 16'h4000);
    s_valid = 1'b1; s_data = 16'h4000;

    // Soft mute, consume while muted, then unmute.
    mute = 1'b1;
    next_strobe();
    next_strobe(); chk("mute1", sd_in, 16'h3000);
    next_strobe(); chk("mute2", sd_in, 16'h2000);
    next_strobe(); chk("mute3", sd_in, 16'h1000);
    next_strobe(); chk("mute4", sd_in, 16'h0000);
    chk("muted_state", state, 4);
    s_data = 16'h7FFF;
    repeat (2) next_strobe();
    chk("muted_sd_in", sd_in, 16'h0000);
    s_data = 16'h4000; mute = 1'b0;
    repeat (5) next_strobe();
    chk("unmute_state", state, 2);

    // Disable: ramp to idle.
    en = 1'b0;
    repeat (5) next_strobe();
    chk("off_state", state, 0);
    chk("off_sd_rst_n", sd_rst_n, 0);

    // Floor rounding of -1, then disable mid ramp-up at g=128.
    en = 1'b1; s_data = 16'hFFFF;
    cyc();
    chk("reen_underrun", underrun_cnt, 0);
    next_strobe(); next_strobe();
    chk("floor_sd_in", sd_in, 16'hFFFF);
    en = 1'b0; s_data = 16'h4000;
    next_strobe(); chk("abort_turn", sd_in, 16'h2000);
    next_strobe(); chk("abort_64", sd_in, 16'h1000);
    chk("abort_state", state, 3);
    next_strobe(); chk("abort_0", sd_in, 16'h0000);
    chk("abort_sd_rst_n", sd_rst_n, 0);
    cyc();

    // Most negative sample at unity gain.
    en = 1'b1; s_data = 16'h8000;
    cyc();
    repeat (4) next_strobe();
    chk("neg_full_sd_in", sd_in, 16'h8000);

    // Randomized traffic, controls and period changes.
    for (int i = 0; i < 900; i++) begin
      s_data  = 16'($urandom);
      s_valid = ($urandom_range(0, 3) != 0);
      osr_div = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 99) < 2) en = ~en;
      if ($urandom_range(0, 99) < 3) mute = ~mute;
      cyc();
    end

    // Asynchronous reset mid-period in RUN.
    en = 1'b1; mute = 1'b0; s_valid = 1'b1; s_data = 16'h4000; osr_div = 8'd7;
    for (int i = 0; i < 200 && !(m_state == 2 && m_wait == 4); i++) cyc();
    chk("pre_rst_state", state, 2);
    rst_n = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_sd_in", sd_in, 16'h0000);
    chk("arst_sd_rst_n", sd_rst_n, 0);
    chk("arst_s_ready", s_ready, 0);
    chk("arst_underrun", underrun_cnt, 0);
    model_reset();
    cyc();
    rst_n = 1'b1;
    cyc();
    next_strobe();
    chk("restart_sd_in", sd_in, 16'h1000);
    chk("restart_state", state, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
